lsu_byte_sequencer: RTL and testbench
=====================================

# lsu_byte_sequencer

Load/store sequencer between the MEM pipeline stage and the byte-wide data memory. It accepts one byte, halfword or word access per request and issues it to memory as consecutive single-byte transfers, most significant byte first at the lowest address (big-endian). For loads it assembles the returned bytes and applies sign or zero extension. It stalls the pipeline through `req_ready` while a transfer is in flight.

## Interface
Parameters:
- `ADDR_W`, 8: memory byte-address width (256 bytes).

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = word.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address; only bits [ADDR_W-1:0] are used.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  access rejected; valid with `resp_valid`.
- `mem_addr`  out  ADDR_W  byte address to memory.
- `mem_wdata`  out  8  byte to write.
- `mem_we`  out  1  write strobe, one byte per cycle.
- `mem_re`  out  1  read strobe; data returns the next cycle.
- `mem_rdata`  in  8  read byte, valid the cycle after `mem_re`.

## Operation
- Transfer length N: 1, 2 or 4 bytes, from `req_size`.
- States:
  - IDLE: `req_ready`=1. When `req_valid` is high, latch the request, set byte index k=0, and go to XFER. If the request is rejected, go to RESP with `resp_err`=1 instead.
  - XFER: issue byte k at `mem_addr` = (base+k) mod 2^ADDR_W.
    - Store: `mem_we`=1 and `mem_wdata` = `req_wdata[8*(N-1-k)+:8]`.
    - Load: `mem_re`=1.
    - After k=N-1, a store goes to RESP and a load goes to DRAIN.
  - DRAIN (loads only): capture the last byte, then go to RESP.
  - RESP: `resp_valid`=1 for one cycle, then return to IDLE.
- Load assembly: every cycle after a cycle with `mem_re`=1, shift `acc` = {acc[23:0], mem_rdata}.
- Load result:
  - Byte: `acc[7:0]` extended to 32 bits.
  - Half: `acc[15:0]` extended to 32 bits.
  - Word: `acc[31:0]`.
  - Extension is sign or zero according to the latched `req_unsigned`.
- Request inputs are sampled only on acceptance; later changes have no effect.
- `resp_valid` has no backpressure; the consumer must take it in that cycle.
- Address wrap: an access that starts near the top of memory continues at 0. Example: a word at address 0xFE uses 0xFE, 0xFF, 0x00, 0x01.
- Strobes are never asserted outside XFER.
- `mem_we` and `mem_re` are never high in the same cycle.

## Timing
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_we`=0, `mem_re`=0, `mem_addr`=0, `mem_wdata`=0. State is IDLE and `acc`=0.
- Request accepted at edge T; then:
  - Strobes are high for cycles T+1 .. T+N.
  - Store: `resp_valid` at T+N+1.
  - Load: last byte returns at T+N+1; `resp_valid` at T+N+2.
  - Error: `resp_valid` and `resp_err` at T+1, with no strobes.
- `req_ready` is high only in IDLE, so the next acceptance is possible one cycle after RESP.
- Word load: 6 cycles from request to response. Byte store: 2 cycles.
- Reset asserted mid-transfer:
  - Strobes drop immediately, without waiting for a clock edge.
  - The partial transfer is abandoned and no response is produced.
  - Bytes already written stay written.
- Outputs are registered. `req_ready` is decoded from state only, with no combinational path from `req_valid`.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined: an access is rejected when `req_size`=01 with `addr[0]`=1, or when `req_size`=1x with `addr[1:0]`≠0.
  - A rejected access produces `resp_err`=1 and `resp_rdata`=0.
  - No memory strobes are issued for a rejected access.
- Not defined:
  - No request is ever rejected.
  - Misaligned accesses proceed byte by byte from the given address.
  - `resp_err` is tied to 0.

## Test plan
- Word store, then word load at 0x10:
  - Store 0x11223344: bytes 11, 22, 33, 44 written to 0x10–0x13 on T+1..T+4; `resp_valid` at T+5.
  - Load from 0x10: returns 0x11223344 at T+6.
- Byte load at 0x20 holding 0x80:
  - `req_unsigned`=0 → 0xFFFFFF80.
  - `req_unsigned`=1 → 0x00000080.
- Half load at 0x30 holding 0xF0 0x01 → 0xFFFFF001 with `req_unsigned`=0.
  - Half store of `req_wdata`=0xABCD1234 at 0x30 → writes 12, 34; upper bits are ignored.
- Wrap: word store of 0xDEADBEEF at 0xFE → DE at 0xFE, AD at 0xFF, BE at 0x00, EF at 0x01.
- Misaligned word at 0x02:
  - With `LSU_ALIGN_CHECK_EN`: `resp_err`=1 at T+1 and zero strobes.
  - Without it: a normal 4-byte access over 0x02–0x05.
- `rst_n` pulsed low during the second byte of a word store:
  - `mem_we` drops immediately and no `resp_valid` is produced.
  - After release, `req_ready`=1 and the next request completes normally.

Source files
------------

// File: rtl/lsu_byte_sequencer_if.sv
// Pipeline-side request/response and byte-wide memory port bundle for lsu_byte_sequencer.
// Latency: n/a (signal bundle only); backpressure: req_ready only, responses are never stalled.
interface lsu_byte_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// Splits byte/half/word loads and stores into big-endian single-byte memory transfers.
// Latency: store N+1, load N+2, rejected 1 cycle after accept; optional LSU_ALIGN_CHECK_EN rejects misaligned accesses.
// Backpressure: req_ready high only in IDLE; resp_valid is a one-cycle pulse with no stall.
module lsu_byte_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lsu_byte_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;

    state_t            state, state_nxt;
    logic [1:0]        k, k_nxt, last;
    logic              wr_q, uns_q, re_d;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q, acc, acc_nxt;
    logic              misalign;

    logic              we_q, re_q, rv_q, err_q;
    logic              we_nxt, re_nxt, rv_nxt, err_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [7:0]        wd_q, wd_nxt;
    logic [31:0]       rdata_q, rdata_nxt;

    wire unused_addr = &{1'b0, bus.req_addr[31:ADDR_W]};

`ifdef LSU_ALIGN_CHECK_EN
    assign misalign = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                      (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [7:0] pick(input logic [31:0] d, input logic [1:0] idx);
        case (idx)
            2'd0:    return d[7:0];
            2'd1:    return d[15:8];
            2'd2:    return d[23:16];
            default: return d[31:24];
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] a, input logic [1:0] size,
                                           input logic uns);
        case (size)
            2'b00:   return uns ? {24'h0, a[7:0]}  : {{24{a[7]}}, a[7:0]};
            2'b01:   return uns ? {16'h0, a[15:0]} : {{16{a[15]}}, a[15:0]};
            default: return a;
        endcase
    endfunction

    assign last = last_idx(size_q);

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        we_nxt    = 1'b0;
        re_nxt    = 1'b0;
        rv_nxt    = 1'b0;
        err_nxt   = 1'b0;
        addr_nxt  = addr_q;
        wd_nxt    = wd_q;
        rdata_nxt = rdata_q;
        // Returned byte arrives one cycle after its read strobe.
        acc_nxt   = re_d ? {acc[23:0], bus.mem_rdata} : acc;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (misalign) begin
                        state_nxt = RESP;
                        rv_nxt    = 1'b1;
                        err_nxt   = 1'b1;
                        rdata_nxt = 32'h0;
                    end else begin
                        state_nxt = XFER;
                        k_nxt     = 2'd0;
                        addr_nxt  = bus.req_addr[ADDR_W-1:0];
                        we_nxt    = bus.req_write;
                        re_nxt    = !bus.req_write;
                        wd_nxt    = bus.req_write ?
                                    pick(bus.req_wdata, last_idx(bus.req_size)) : 8'h00;
                    end
                end
            end
            XFER: begin
                if (k == last) begin
                    state_nxt = wr_q ? RESP : DRAIN;
                    if (wr_q) begin
                        rv_nxt    = 1'b1;
                        rdata_nxt = 32'h0;
                    end
                end else begin
                    k_nxt    = k + 2'd1;
                    addr_nxt = base_q + {{(ADDR_W-2){1'b0}}, k + 2'd1};
                    we_nxt   = wr_q;
                    re_nxt   = !wr_q;
                    wd_nxt   = wr_q ? pick(wdata_q, last - k - 2'd1) : 8'h00;
                end
            end
            DRAIN: begin
                state_nxt = RESP;
                rv_nxt    = 1'b1;
                rdata_nxt = extend(acc_nxt, size_q, uns_q);
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= 2'd0;
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            base_q  <= '0;
            wdata_q <= 32'h0;
            acc     <= 32'h0;
            re_d    <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wd_q    <= 8'h00;
            rdata_q <= 32'h0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                wr_q    <= bus.req_write;
                uns_q   <= bus.req_unsigned;
                size_q  <= bus.req_size;
                base_q  <= bus.req_addr[ADDR_W-1:0];
                wdata_q <= bus.req_wdata;
            end
            state   <= state_nxt;
            k       <= k_nxt;
            acc     <= acc_nxt;
            re_d    <= re_q;
            we_q    <= we_nxt;
            re_q    <= re_nxt;
            rv_q    <= rv_nxt;
            err_q   <= err_nxt;
            addr_q  <= addr_nxt;
            wd_q    <= wd_nxt;
            rdata_q <= rdata_nxt;
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = rv_q;
    assign bus.resp_err   = err_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wd_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_re     = re_q;
endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Scoreboard bench for lsu_byte_sequencer with a 256-byte memory model.
module tb_lsu_byte_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_byte_sequencer_if #(.ADDR_W(8)) bus ();
    lsu_byte_sequencer #(.ADDR_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] wq[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          strobe_cnt = 0;

    logic [7:0] mem [0:255];
    logic [7:0] rd_q;
    always @(posedge clk) begin
        if (bus.mem_re) rd_q <= mem[bus.mem_addr];
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = rd_q;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_we | bus.mem_re) begin
                strobe_cnt++;
                check("we_re_excl", {31'b0, bus.mem_we & bus.mem_re}, 32'd0);
            end
            if (bus.mem_we) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected", {31'b0, bus.mem_we}, 32'd0);
                end else begin
                    logic [15:0] w;
                    w = wq.pop_front();
                    check("wr_addr", {24'b0, bus.mem_addr}, {24'b0, w[15:8]});
                    check("wr_data", {24'b0, bus.mem_wdata}, {24'b0, w[7:0]});
                end
            end
            if (bus.resp_valid) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", {31'b0, bus.resp_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_rdata", bus.resp_rdata, e.rdata);
                    check("resp_err", {31'b0, bus.resp_err}, {31'b0, e.err});
                    check("resp_latency", 32'(cyc - e.t0), 32'(e.lat));
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) check("ready_timeout", {31'b0, bus.req_ready}, 32'd1);
    endtask

    task automatic send(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
        int   nb;
        exp_t e;
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        wait_ready();
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = exp_err ? 1 : (wr ? nb + 1 : nb + 2);
        e.t0    = cyc;
        sb.push_back(e);
        if (wr && !exp_err) begin
            for (int k = 0; k < nb; k++) begin
                logic [31:0] sh;
                sh = wd >> (8 * (nb - 1 - k));
                wq.push_back({addr[7:0] + 8'(k), sh[7:0]});
            end
        end
        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.req_wdata    = $urandom;
        bus.req_addr     = $urandom;
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_write    = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !bus.req_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int s0;
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        mem[8'h20] <= 8'h80;
        mem[8'h30] <= 8'hF0;
        mem[8'h31] <= 8'h01;
        mem[8'h02] <= 8'hA1;
        mem[8'h03] <= 8'hB2;
        mem[8'h04] <= 8'hC3;
        mem[8'h05] <= 8'hD4;
        #3;
        check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst_resp_err", {31'b0, bus.resp_err}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        check("rst_mem_re", {31'b0, bus.mem_re}, 32'd0);
        check("rst_mem_addr", {24'b0, bus.mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'b0, bus.mem_wdata}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1122_3344, 32'h0, 1'b0);
        send(1'b0, 2'b10, 1'b0, 32'hFFFF_FF10, 32'h0,         32'h1122_3344, 1'b0);
        send(1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'h0,         32'hFFFF_FF80, 1'b0);
        send(1'b0, 2'b00, 1'b1, 32'h0000_0020, 32'h0,         32'h0000_0080, 1'b0);
        send(1'b0, 2'b01, 1'b0, 32'h0000_0030, 32'h0,         32'hFFFF_F001, 1'b0);
        send(1'b0, 2'b01, 1'b1, 32'h0000_0030, 32'h0,         32'h0000_F001, 1'b0);
        send(1'b1, 2'b01, 1'b0, 32'h0000_0030, 32'hABCD_1234, 32'h0, 1'b0);
        send(1'b0, 2'b01, 1'b0, 32'h0000_0030, 32'h0,         32'h0000_1234, 1'b0);
        send(1'b1, 2'b10, 1'b0, 32'h0000_00FE, 32'hDEAD_BEEF, 32'h0, 1'b0);
        send(1'b0, 2'b10, 1'b1, 32'h0000_00FE, 32'h0,         32'hDEAD_BEEF, 1'b0);
        send(1'b1, 2'b00, 1'b0, 32'h0000_0050, 32'h1234_5677, 32'h0, 1'b0);
        send(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         32'h1122_3344, 1'b0);
        wait_idle();
        check("wrap_byte_00", {24'b0, mem[8'h00]}, 32'hBE);
        check("wrap_byte_01", {24'b0, mem[8'h01]}, 32'hEF);

        s0 = strobe_cnt;
`ifdef LSU_ALIGN_CHECK_EN
        send(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0, 32'h0, 1'b1);
        send(1'b0, 2'b01, 1'b0, 32'h0000_0031, 32'h0, 32'h0, 1'b1);
        wait_idle();
        check("misalign_strobes", 32'(strobe_cnt - s0), 32'd0);
`else
        send(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0, 32'hA1B2_C3D4, 1'b0);
        send(1'b0, 2'b01, 1'b0, 32'h0000_0031, 32'h0, 32'h0000_3400, 1'b0);
        wait_idle();
        check("misalign_strobes", 32'(strobe_cnt - s0), 32'd6);
`endif

        // Reset lands during the second byte of a word store.
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h0000_0040;
        bus.req_wdata = 32'hCAFE_F00D;
        wq.push_back({8'h40, 8'hCA});
        wq.push_back({8'h41, 8'hFE});
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_we_drop", {31'b0, bus.mem_we}, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_hold_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rst_hold_resp", {31'b0, bus.resp_valid}, 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_byte40_kept", {24'b0, mem[8'h40]}, 32'hCA);
        check("rst_byte41_unwritten", {24'b0, mem[8'h41]}, 32'h00);
        check("rst_ready_after", {31'b0, bus.req_ready}, 32'd1);

        send(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h1122_3344, 1'b0);
        wait_idle();
        check("wq_drained", 32'(wq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
